// File: rtl/xalu.sv
// Multiply/divide unit with HI/LO registers: launches mult/multu/div/divu on start,
// holds busy for a fixed cycle count, then commits the result to HI/LO in one edge.
module xalu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  xaluop,
  input  logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] xaluout
);

  localparam int DATA_W  = 32;
  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt_p0, cnt_nxt;
  logic [3:0]          op_p0;
  logic [DATA_W-1:0]   a_p0, b_p0;
  logic [DATA_W-1:0]   hi_q, lo_q;
  logic                launch, done, is_div_p0, res_wr;
  logic [2*DATA_W-1:0] res;

  // Product of two 32-bit operands; sign extension to 64 bits makes the
  // low 64 bits of an unsigned multiply equal the signed product.
  function automatic logic [2*DATA_W-1:0] mul_calc(input logic [DATA_W-1:0] x,
                                                   input logic [DATA_W-1:0] y,
                                                   input logic              sgn);
    logic [2*DATA_W-1:0] xe, ye;
    xe = {{DATA_W{sgn & x[DATA_W-1]}}, x};
    ye = {{DATA_W{sgn & y[DATA_W-1]}}, y};
    return xe * ye;
  endfunction

  // Returns {remainder, quotient}. Signed division works on magnitudes, so
  // 0x80000000 / -1 wraps naturally to quotient 0x80000000, remainder 0.
  function automatic logic [2*DATA_W-1:0] div_calc(input logic [DATA_W-1:0] x,
                                                   input logic [DATA_W-1:0] y,
                                                   input logic              sgn);
    logic              neg_x, neg_y;
    logic [DATA_W-1:0] ux, uy, q, r;
    neg_x = sgn & x[DATA_W-1];
    neg_y = sgn & y[DATA_W-1];
    ux    = neg_x ? (~x + 1'b1) : x;
    uy    = neg_y ? (~y + 1'b1) : y;
    if (uy == '0) begin
      q = '0;
      r = '0;
    end else begin
      q = ux / uy;
      r = ux % uy;
    end
    if (neg_x ^ neg_y) q = ~q + 1'b1;
    if (neg_x)         r = ~r + 1'b1;
    return {r, q};
  endfunction

  always_comb begin
    launch    = (state == IDLE) && start &&
                (xaluop == OP_MULT || xaluop == OP_MULTU ||
                 xaluop == OP_DIV  || xaluop == OP_DIVU);
    done      = (state == BUSY) && (cnt_p0 <= CNT_W'(1));
    is_div_p0 = (op_p0 == OP_DIV) || (op_p0 == OP_DIVU);
    // Divide by zero still runs its full latency but commits nothing.
    res_wr    = done && !(is_div_p0 && (b_p0 == '0));
  end

  always_comb begin
    res = '0;
    case (op_p0)
      OP_MULT:  res = mul_calc(a_p0, b_p0, 1'b1);
      OP_MULTU: res = mul_calc(a_p0, b_p0, 1'b0);
      OP_DIV:   res = div_calc(a_p0, b_p0, 1'b1);
      OP_DIVU:  res = div_calc(a_p0, b_p0, 1'b0);
      default:  res = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_p0;
    case (state)
      IDLE: begin
        if (launch) begin
          state_nxt = BUSY;
          cnt_nxt   = (xaluop == OP_MULT || xaluop == OP_MULTU) ?
                      CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
        end
      end
      BUSY: begin
        if (done) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt_p0 - CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Launch stage: operands are captured once and held for the whole busy window.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt_p0 <= '0;
      op_p0  <= '0;
      a_p0   <= '0;
      b_p0   <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      state  <= state_nxt;
      cnt_p0 <= cnt_nxt;
      if (launch) begin
        op_p0 <= xaluop;
        a_p0  <= a;
        b_p0  <= b;
      end
      // Commit stage: HI/LO change only at completion or via mthi/mtlo in IDLE.
      if (res_wr) begin
        hi_q <= res[2*DATA_W-1:DATA_W];
        lo_q <= res[DATA_W-1:0];
      end else if (state == IDLE) begin
        if (xaluop == OP_MTHI) hi_q <= a;
        if (xaluop == OP_MTLO) lo_q <= a;
      end
    end
  end

  always_comb begin
    busy = (state == BUSY);
    hi   = hi_q;
    lo   = lo_q;
    case (xaluop)
      OP_MFHI: xaluout = hi_q;
      OP_MFLO: xaluout = lo_q;
      default: xaluout = '0;
    endcase
  end

endmodule

// File: tb/tb_xalu.sv
// Randomized and directed bench for xalu against a completion-time reference model.
module tb_xalu;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a, b;
  logic [3:0]  xaluop;
  logic        start;
  logic        busy;
  logic [31:0] hi, lo, xaluout;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: result is computed at launch, applied at the done cycle.
  longint      cyc = 0;
  bit          m_busy = 1'b0;
  longint      m_done = 0;
  bit          m_wr = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0, m_rhi = '0, m_rlo = '0;

  xalu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .xaluop(xaluop), .start(start),
    .busy(busy), .hi(hi), .lo(lo), .xaluout(xaluout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_launch(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    longint      p, q, r;
    longint unsigned pu;
    m_busy = 1'b1;
    m_wr   = 1'b1;
    case (op)
      4'd1: begin
        p = longint'($signed(x)) * longint'($signed(y));
        {m_rhi, m_rlo} = p[63:0];
        m_done = cyc + MULT_N;
      end
      4'd2: begin
        pu = {32'b0, x} * {32'b0, y};
        {m_rhi, m_rlo} = pu[63:0];
        m_done = cyc + MULT_N;
      end
      4'd3: begin
        m_done = cyc + DIV_N;
        if (y == 0) m_wr = 1'b0;
        else begin
          q = longint'($signed(x)) / longint'($signed(y));
          r = longint'($signed(x)) % longint'($signed(y));
          m_rlo = q[31:0];
          m_rhi = r[31:0];
        end
      end
      default: begin
        m_done = cyc + DIV_N;
        if (y == 0) m_wr = 1'b0;
        else begin
          m_rlo = x / y;
          m_rhi = x % y;
        end
      end
    endcase
  endtask

  // Advance the model by one rising edge using the inputs present at that edge.
  task automatic model_edge();
    cyc++;
    if (reset) begin
      m_busy = 1'b0;
      m_hi   = '0;
      m_lo   = '0;
    end else if (m_busy) begin
      if (cyc == m_done) begin
        m_busy = 1'b0;
        if (m_wr) begin
          m_hi = m_rhi;
          m_lo = m_rlo;
        end
      end
    end else if (start && xaluop >= 4'd1 && xaluop <= 4'd4) begin
      model_launch(xaluop, a, b);
    end else if (xaluop == 4'd5) begin
      m_hi = a;
    end else if (xaluop == 4'd6) begin
      m_lo = a;
    end
  endtask

  task automatic step(input logic rst, input logic [3:0] op, input logic st,
                      input logic [31:0] x, input logic [31:0] y);
    logic [31:0] exp_out;
    reset  = rst;
    xaluop = op;
    start  = st;
    a      = x;
    b      = y;
    @(posedge clk);
    model_edge();
    #1;
    exp_out = (op == 4'd7) ? m_hi : (op == 4'd8) ? m_lo : 32'h0;
    chk("busy", {31'b0, busy}, {31'b0, m_busy});
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    chk("xaluout", xaluout, exp_out);
  endtask

  task automatic idle_steps(input int n, input logic [3:0] op);
    for (int i = 0; i < n; i++) step(1'b0, op, 1'b0, $urandom, $urandom);
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    step(1'b1, 4'd0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 4'd5, 1'b1, 32'h1234, 32'h0);
    chk("reset_busy", {31'b0, busy}, 32'h0);
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);

    // mult -2 * 3: busy for exactly five edges, then {HI,LO} = -6
    step(1'b0, 4'd1, 1'b1, 32'hFFFF_FFFE, 32'd3);
    for (int i = 0; i < MULT_N - 1; i++) begin
      step(1'b0, 4'($urandom_range(0, 15)), 1'b0, $urandom, $urandom);
      chk("mult_busy_window", {31'b0, busy}, 32'h1);
      chk("mult_lo_hidden", lo, 32'h0);
    end
    step(1'b0, 4'd8, 1'b0, 32'h0, 32'h0);
    chk("mult_busy_fall", {31'b0, busy}, 32'h0);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);
    chk("mult_mflo", xaluout, 32'hFFFF_FFFA);

    step(1'b0, 4'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    idle_steps(MULT_N, 4'd0);
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'h0000_0001);

    step(1'b0, 4'd3, 1'b1, 32'hFFFF_FFF9, 32'd2);
    idle_steps(DIV_N - 1, 4'd0);
    chk("div_busy_last", {31'b0, busy}, 32'h1);
    idle_steps(1, 4'd0);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    step(1'b0, 4'd4, 1'b1, 32'hFFFF_FFF9, 32'd2);
    idle_steps(DIV_N, 4'd0);
    chk("divu_lo", lo, 32'h7FFF_FFFC);
    chk("divu_hi", hi, 32'h0000_0001);

    step(1'b0, 4'd3, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    idle_steps(DIV_N, 4'd0);
    chk("div_ovf_lo", lo, 32'h8000_0000);
    chk("div_ovf_hi", hi, 32'h0);

    // divide by zero leaves preloaded HI/LO alone
    step(1'b0, 4'd5, 1'b0, 32'h11, 32'h0);
    step(1'b0, 4'd6, 1'b0, 32'h22, 32'h0);
    step(1'b0, 4'd3, 1'b1, 32'd5, 32'd0);
    idle_steps(DIV_N - 1, 4'd0);
    chk("div0_busy", {31'b0, busy}, 32'h1);
    idle_steps(1, 4'd7);
    chk("div0_busy_fall", {31'b0, busy}, 32'h0);
    chk("div0_hi", hi, 32'h11);
    chk("div0_lo", lo, 32'h22);

    // reset on the second busy edge discards the pending product
    step(1'b0, 4'd5, 1'b0, 32'h55, 32'h0);
    step(1'b0, 4'd1, 1'b1, 32'd3, 32'd4);
    step(1'b0, 4'd0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 4'd6, 1'b1, 32'h99, 32'h0);
    chk("rst_mid_busy", {31'b0, busy}, 32'h0);
    chk("rst_mid_hi", hi, 32'h0);
    idle_steps(MULT_N, 4'd0);
    chk("rst_mid_hi_late", hi, 32'h0);
    chk("rst_mid_lo_late", lo, 32'h0);

    // start during busy is ignored
    step(1'b0, 4'd1, 1'b1, 32'd2, 32'd2);
    step(1'b0, 4'd0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 4'd0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 4'd4, 1'b1, 32'd9, 32'd3);
    step(1'b0, 4'd0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 4'd0, 1'b0, 32'h0, 32'h0);
    chk("ign_start_lo", lo, 32'd4);
    chk("ign_start_hi", hi, 32'd0);
    chk("ign_start_busy", {31'b0, busy}, 32'h0);

    for (int i = 0; i < 3000; i++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 8));
      step(($urandom_range(0, 99) == 0), op, ($urandom_range(0, 2) == 0),
           rnd_operand(), rnd_operand());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/xalu.md
XALU -- requirements
Module: xalu

Interface
REQ-001 Parameter MULT_CYCLES, default 5, number of cycles busy stays high for mult/multu.
REQ-002 Parameter DIV_CYCLES, default 10, number of cycles busy stays high for div/divu.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset:
- clk  input  1  clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have these remaining ports:
- a  input  32  operand A (rs value, forwarded); source for mthi/mtlo.
- b  input  32  operand B (rt value, forwarded).
- xaluop  input  4  operation code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo, 9-15 none.
- start  input  1  one-cycle pulse launching ops 1-4.
- busy  output  1  computation in progress.
- hi  output  32  HI register.
- lo  output  32  LO register.
- xaluout  output  32  read data for mfhi/mflo.

Function
REQ-005 The block SHALL hold HI and LO as 32-bit registers, with hi/lo outputs driven directly from them.
REQ-006 xaluout SHALL be combinational from the current registers: HI when xaluop==7, LO when xaluop==8, otherwise 0.
REQ-007 The block SHALL be a two-state FSM: IDLE and BUSY. busy SHALL equal 1 exactly in BUSY.
REQ-008 In IDLE, start==1 with xaluop in 1..4 SHALL, at that edge:
- latch a, b and the op;
- load the down-counter with MULT_CYCLES or DIV_CYCLES;
- enter BUSY.
REQ-009 For a launch at edge k, busy SHALL be 1 from after edge k through edge k+N, where N is the op's cycle count. At edge k+N, HI/LO SHALL update, busy SHALL fall and the FSM SHALL return to IDLE.
REQ-010 Results:
- mult: {HI,LO} = signed 64-bit product.
- multu: {HI,LO} = unsigned 64-bit product.
- div: LO = signed quotient truncated toward zero; HI = remainder carrying the sign of the dividend.
- divu: LO = unsigned quotient; HI = unsigned remainder.
REQ-011 div of 0x80000000 by 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0.
REQ-012 Division by zero (div or divu) SHALL run the full DIV_CYCLES with busy high, then leave HI and LO unchanged.
REQ-013 Results SHALL be computed from the operands latched at launch. Changes on a, b or xaluop during BUSY SHALL NOT affect the result.
REQ-014 start SHALL be ignored in BUSY, and in IDLE when xaluop is not in 1..4.
REQ-015 In IDLE with xaluop==5, HI SHALL load a at the edge; with xaluop==6, LO SHALL load a at the edge. start is irrelevant to these ops.
REQ-016 In BUSY, xaluop 5/6 SHALL be ignored. The pipeline stalls on busy|start, so this case does not occur legally.
REQ-017 During BUSY, hi, lo and xaluout SHALL show the pre-launch values. Pending results SHALL NOT be visible early.
REQ-018 A new launch in the same edge that busy falls is not possible. The earliest relaunch SHALL be edge k+N+1, from IDLE.
REQ-019 Multiplier and divider internals are free (multi-cycle iterative or single-cycle compute plus delay counter), provided the REQ-009 timing is exact.

Reset
REQ-020 reset==1 at an edge SHALL force, regardless of state:
- FSM to IDLE, busy to 0;
- HI and LO to 0;
- counter to 0;
- latched operands discarded.
REQ-021 Reset mid-operation SHALL discard the pending result. No HI/LO update from that operation SHALL ever occur.
REQ-022 reset SHALL take priority over start and over xaluop 5/6 in the same cycle.

Verification
REQ-023 mult: a=0xFFFFFFFE (-2), b=3, start at edge k -> busy 1 for edges k+1..k+5; after edge k+5, HI=0xFFFFFFFF and LO=0xFFFFFFFA; xaluout=0xFFFFFFFA with xaluop=8.
REQ-024 multu: a=0xFFFFFFFF, b=0xFFFFFFFF -> after 5 cycles, HI=0xFFFFFFFE and LO=0x00000001.
REQ-025 div and divu:
- div a=-7 (0xFFFFFFF9), b=2 -> after 10 cycles, LO=0xFFFFFFFD and HI=0xFFFFFFFF.
- divu with the same operands -> LO=0x7FFFFFFC and HI=0x00000001.
REQ-026 Divide by zero: preload HI=0x11 (mthi) and LO=0x22 (mtlo), then div a=5, b=0 -> busy high for 10 cycles, HI=0x11 and LO=0x22 unchanged.
REQ-027 Reset mid-operation: launch mult a=3, b=4, assert reset at cycle 2 of BUSY -> busy=0, HI=LO=0 after that edge; HI/LO stay 0 at the would-be completion edge.
REQ-028 Start during BUSY: launch mult a=2, b=2; at cycle 3, start with divu a=9, b=3 -> ignored; after edge k+5, LO=4 and HI=0; busy low at edge k+6.
